// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - counted, handshaked 1-bit-per-cycle shift sequencer
// Accepts one job on the request port, steps it amt times, holds the result until taken.
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic [AMT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       op, op_nxt;

    function automatic logic [WIDTH-1:0] step(input logic [1:0] f, input logic [WIDTH-1:0] v);
        case (f)
            OP_SLL:  step = {v[WIDTH-2:0], 1'b0};
            OP_SRL:  step = {1'b0, v[WIDTH-1:1]};
            OP_SRA:  step = {v[WIDTH-1], v[WIDTH-1:1]};
            default: step = {v[WIDTH-2:0], v[WIDTH-1]};
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
            op    <= 2'b00;
        end else if (en) begin
            state <= state_nxt;
            sreg  <= sreg_nxt;
            cnt   <= cnt_nxt;
            op    <= op_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        cnt_nxt   = cnt;
        op_nxt    = op;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    sreg_nxt  = in_data;
                    cnt_nxt   = in_amt;
                    op_nxt    = in_op;
                    state_nxt = (in_amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                sreg_nxt = step(op, sreg);
                cnt_nxt  = cnt - AMT_W'(1);
                // Last step lands the result and moves straight to DONE.
                if (cnt == AMT_W'(1))
                    state_nxt = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == SHIFT) || (state == DONE);
    assign out_data  = sreg;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed testbench for shift_sequencer
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_amt;
    logic [1:0] in_op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;

    shift_sequencer #(.WIDTH(8), .AMT_W(3)) dut (
        .clk(clk), .rst(rst), .en(en),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_amt(in_amt), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [7:0] d, input logic [2:0] a, input logic [1:0] o);
        in_valid = 1'b1; in_data = d; in_amt = a; in_op = o;
        tick();
        in_valid = 1'b0; in_data = 8'h00; in_amt = 3'd0; in_op = 2'b00;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0;
        tick(); tick();
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL reset_out_data got %h want 00", out_data); end
        rst = 1'b0; en = 1'b1;
        tick();
    endtask

    task automatic test_sll;
        accept(8'hAA, 3'd3, 2'b00);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL sll_busy got %b want 1", busy); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL sll_in_ready got %b want 0", in_ready); end
        for (int i = 1; i < 3; i++) begin
            tick();
            vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL sll_early_valid got %b want 0 at E%0d", out_valid, i); end
        end
        tick();
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL sll_valid got %b want 1", out_valid); end
        vectors++; if (out_data !== 8'h50) begin miscompares++; $display("FAIL sll_data got %h want 50", out_data); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL sll_return_idle got %b want 1", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL sll_valid_drop got %b want 0", out_valid); end
    endtask

    task automatic test_sra_srl;
        accept(8'hAA, 3'd2, 2'b10);
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL sra_early_valid got %b want 0", out_valid); end
        tick();
        vectors++; if (out_valid !== 1'b1 || out_data !== 8'hEA) begin miscompares++; $display("FAIL sra_result got v=%b d=%h want v=1 d=ea", out_valid, out_data); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        accept(8'hAA, 3'd7, 2'b01);
        for (int i = 1; i < 7; i++) begin
            tick();
            vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL srl_early_valid got %b want 0 at E%0d", out_valid, i); end
        end
        tick();
        vectors++; if (out_valid !== 1'b1 || out_data !== 8'h01) begin miscompares++; $display("FAIL srl_result got v=%b d=%h want v=1 d=01", out_valid, out_data); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_rol_zero;
        accept(8'hAA, 3'd1, 2'b11);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rol_early_valid got %b want 0", out_valid); end
        tick();
        vectors++; if (out_valid !== 1'b1 || out_data !== 8'h55) begin miscompares++; $display("FAIL rol_result got v=%b d=%h want v=1 d=55", out_valid, out_data); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        accept(8'hAA, 3'd0, 2'b01);
        vectors++; if (out_valid !== 1'b1 || out_data !== 8'hAA) begin miscompares++; $display("FAIL zero_amt got v=%b d=%h want v=1 d=aa", out_valid, out_data); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_stall_backpressure;
        accept(8'h81, 3'd4, 2'b00);
        tick();
        vectors++; if (out_data !== 8'h02) begin miscompares++; $display("FAIL stall_pre got %h want 02", out_data); end
        en = 1'b0;
        tick(); tick();
        vectors++; if (out_data !== 8'h02 || out_valid !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL stall_frozen got d=%h v=%b b=%b want d=02 v=0 b=1", out_data, out_valid, busy); end
        en = 1'b1;
        tick(); tick();
        vectors++; if (out_data !== 8'h08 || out_valid !== 1'b0) begin miscompares++; $display("FAIL stall_resume got d=%h v=%b want d=08 v=0", out_data, out_valid); end
        tick();
        vectors++; if (out_valid !== 1'b1 || out_data !== 8'h10) begin miscompares++; $display("FAIL stall_result got v=%b d=%h want v=1 d=10", out_valid, out_data); end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (out_valid !== 1'b1 || out_data !== 8'h10) begin miscompares++; $display("FAIL backpressure_hold got v=%b d=%h want v=1 d=10", out_valid, out_data); end
        end
        en = 1'b0; out_ready = 1'b1;
        tick();
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL en_low_handshake got %b want 1", out_valid); end
        en = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors++; if (in_ready !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL stall_return_idle got r=%b b=%b want r=1 b=0", in_ready, busy); end
    endtask

    task automatic test_busy_reject;
        accept(8'h0F, 3'd2, 2'b00);
        in_valid = 1'b1; in_data = 8'hFF; in_amt = 3'd1; in_op = 2'b01;
        tick();
        vectors++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL reject_mid got r=%b v=%b want r=0 v=0", in_ready, out_valid); end
        tick();
        vectors++; if (out_valid !== 1'b1 || out_data !== 8'h3C || in_ready !== 1'b0) begin miscompares++; $display("FAIL reject_first got v=%b d=%h r=%b want v=1 d=3c r=0", out_valid, out_data, in_ready); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL reject_handshake got r=%b v=%b want r=1 v=0", in_ready, out_valid); end
        tick();
        vectors++; if (busy !== 1'b1 || in_ready !== 1'b0) begin miscompares++; $display("FAIL held_accept got b=%b r=%b want b=1 r=0", busy, in_ready); end
        in_valid = 1'b0;
        tick();
        vectors++; if (out_valid !== 1'b1 || out_data !== 8'h7F) begin miscompares++; $display("FAIL held_result got v=%b d=%h want v=1 d=7f", out_valid, out_data); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        accept(8'hAA, 3'd6, 2'b11);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00 || busy !== 1'b0) begin miscompares++; $display("FAIL reset_mid got r=%b v=%b d=%h b=%b want r=1 v=0 d=00 b=0", in_ready, out_valid, out_data, busy); end
        for (int i = 0; i < 8; i++) begin
            tick();
            vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_stale got %b want 0 at cycle %0d", out_valid, i); end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        in_amt = 3'd0; in_op = 2'b00; out_ready = 1'b0;
        test_reset();
        test_sll();
        test_sra_srl();
        test_rol_zero();
        test_stall_backpressure();
        test_busy_reject();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Controller that sequences a WIDTH-bit shift datapath. It accepts one shift job at a time through a valid/ready request port, then steps the internal shift register one bit position per enabled cycle until the requested amount is done. It presents the result on a valid/ready response port. It sits between the control logic and the shift unit and replaces free-running shifting with counted, handshaked operations.

Parameters:
WIDTH, 8, data width of operand and result
AMT_W, 3, width of shift-amount field; must equal clog2(WIDTH); amounts 0..WIDTH-1

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous active-high reset
en  input  1  global enable; when low, all state holds
in_valid  input  1  request valid
in_ready  output  1  sequencer can accept a request
in_data  input  WIDTH  operand
in_amt  input  AMT_W  shift amount
in_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  WIDTH  result (shift register contents)
busy  output  1  high in SHIFT or DONE

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst, sampled on the rising edge; rst takes priority over en.
- Reset values: state=IDLE, shift register=0, counter=0, latched op=00. Outputs: in_ready=1, out_valid=0, busy=0, out_data=0.
- All outputs are decoded from registered state (Moore). There are no combinational paths from inputs to outputs.
- FSM states: IDLE, SHIFT, DONE. All transitions and register updates happen only on edges where en=1.
- IDLE: in_ready=1. If in_valid=1, then on the edge:
  - register <= in_data, counter <= in_amt, op latched;
  - next state is DONE if in_amt=0, otherwise SHIFT.
- SHIFT: in_ready=0. Each enabled edge applies one 1-bit step of the latched op and decrements the counter. When the counter equals 1 on that edge, the next state is DONE.
  - SLL: shift left, zero fill into bit 0.
  - SRL: shift right, zero fill into the MSB.
  - SRA: shift right, the MSB is replicated.
  - ROL: bit WIDTH-1 moves into bit 0.
- DONE: out_valid=1, out_data=register, in_ready=0. If out_ready=1 on the edge, next state is IDLE. Otherwise out_valid and out_data hold stable.
- Latency: with acceptance at enabled edge E0, out_valid rises after edge E(amt) when counting enabled edges only. For amt=0, out_valid rises after E0.
- Throughput: one job per amt+2 enabled cycles minimum. Because in_ready=0 in DONE, a new request is taken no earlier than the cycle after the response handshake.
- en low in any state: state, register, counter and outputs hold. Handshakes do not complete while en=0, even if valid and ready are both high.
- in_valid while busy: ignored, and the request must be held by the requester. Inputs are sampled only at acceptance, so later changes to in_data, in_amt or in_op do not affect an in-flight job.
- rst mid-operation: the job is discarded and the next cycle shows the reset values. No out_valid is produced for the discarded job.
- Counter never wraps; amounts 0..WIDTH-1 are all legal.

Test Plan:
- Reset, then SLL: in_data=0xAA, in_amt=3, in_op=00 accepted at edge E0. Required: busy=1 after E0, out_valid=1 after E3, out_data=0x50; out_ready=1 returns the block to IDLE with in_ready=1 on the next cycle.
- SRA and SRL: 0xAA, amt=2, op=10 gives 0xEA. 0xAA, amt=7, op=01 gives 0x01 with out_valid after E7.
- ROL and zero amount: 0xAA, amt=1, op=11 gives 0x55. 0xAA, amt=0, any op gives out_valid immediately after E0 with out_data=0xAA.
- Stall and backpressure: SLL 0x81 by 4 with en=0 for 2 cycles mid-SHIFT. Required: counter and register frozen, out_valid after 4 enabled edges, out_data=0x10. Then hold out_ready=0 for 3 cycles: out_valid stays 1 and out_data stays 0x10.
- Busy rejection: a second in_valid with 0xFF during SHIFT is not accepted and in_ready stays 0. The first result is unaffected. The held request is accepted on the cycle after the response handshake.
- Reset mid-shift: assert rst 2 cycles into a 6-step job. The next cycle shows IDLE, in_ready=1, out_valid=0, out_data=0, and no stale result ever appears.
